// File: rtl/loopback_wr_engine.sv
// loopback_wr_engine
//   Drain side of the loopback FIFO. Pops cache lines from a show-ahead FIFO,
//   turns each popped line into one registered write request at consecutive
//   line addresses, and tracks outstanding write responses. The engine reports
//   completion once every issued write has been acknowledged.
module loopback_wr_engine #(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 42,
  parameter int LEN_WIDTH       = 32,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  num_lines,
  input  logic [DATA_WIDTH-1:0] fifo_deq_data,
  input  logic                  fifo_empty,
  output logic                  fifo_deq_en,
  input  logic                  wr_almost_full,
  output logic                  wr_req_valid,
  output logic [ADDR_WIDTH-1:0] wr_req_addr,
  output logic [DATA_WIDTH-1:0] wr_req_data,
  input  logic                  wr_rsp_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  resp_error,
  output logic [LEN_WIDTH-1:0]  lines_sent,
  output logic [LEN_WIDTH-1:0]  lines_acked
);

  // Outstanding counter must be able to hold MAX_OUTSTANDING itself.
  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]            state_q,       state_d;
  logic [ADDR_WIDTH-1:0] base_q,        base_d;
  logic [LEN_WIDTH-1:0]  num_q,         num_d;
  logic [LEN_WIDTH-1:0]  sent_q,        sent_d;
  logic [LEN_WIDTH-1:0]  acked_q,       acked_d;
  logic [OUT_W-1:0]      outstanding_q, outstanding_d;
  logic                  resp_err_q,    resp_err_d;
  logic                  req_valid_q,   req_valid_d;
  logic [ADDR_WIDTH-1:0] req_addr_q,    req_addr_d;
  logic [DATA_WIDTH-1:0] req_data_q,    req_data_d;
  logic                  busy_q,        busy_d;
  logic                  done_q,        done_d;

  logic                  idle_like_s;
  logic                  start_acc_s;
  logic                  issue_s;
  logic                  rsp_counted_s;
  logic                  rsp_stray_s;
  logic [ADDR_WIDTH-1:0] issue_addr_s;

  // A start is only honoured when no job is in flight.
  assign idle_like_s = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign start_acc_s = start && idle_like_s;

  // One line moves from FIFO to write channel when every resource is free.
  assign issue_s = (state_q == ST_RUN) && !fifo_empty && !wr_almost_full &&
                   (outstanding_q < OUT_W'(MAX_OUTSTANDING)) &&
                   (sent_q < num_q);

  // Responses only count while a job can legally have writes outstanding.
  assign rsp_counted_s = wr_rsp_valid &&
                         ((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                         (outstanding_q != {OUT_W{1'b0}});
  assign rsp_stray_s   = wr_rsp_valid && !rsp_counted_s;

  // Line address wraps naturally at the address width.
  assign issue_addr_s = base_q + ADDR_WIDTH'(sent_q);

  assign fifo_deq_en = issue_s;
  assign wr_req_valid = req_valid_q;
  assign wr_req_addr  = req_addr_q;
  assign wr_req_data  = req_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign resp_error   = resp_err_q;
  assign lines_sent   = sent_q;
  assign lines_acked  = acked_q;

  // Job control state machine.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (num_lines == {LEN_WIDTH{1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (sent_q == num_q) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (outstanding_q == {OUT_W{1'b0}}) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Job parameters and progress counters; start restarts them.
  always_comb begin
    base_d  = base_q;
    num_d   = num_q;
    sent_d  = sent_q;
    acked_d = acked_q;
    if (start_acc_s) begin
      base_d  = base_addr;
      num_d   = num_lines;
      sent_d  = {LEN_WIDTH{1'b0}};
      acked_d = {LEN_WIDTH{1'b0}};
    end else begin
      if (issue_s) begin
        sent_d = sent_q + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        sent_d = sent_q;
      end
      if (rsp_counted_s) begin
        acked_d = acked_q + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        acked_d = acked_q;
      end
    end
  end

  // Outstanding writes: issue and counted response in one cycle cancel out.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({issue_s, rsp_counted_s})
      2'b10:   outstanding_d = outstanding_q + {{(OUT_W-1){1'b0}}, 1'b1};
      2'b01:   outstanding_d = outstanding_q - {{(OUT_W-1){1'b0}}, 1'b1};
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Sticky stray-response flag, cleared by an accepted start.
  always_comb begin
    resp_err_d = resp_err_q;
    if (rsp_stray_s) begin
      resp_err_d = 1'b1;
    end else if (start_acc_s) begin
      resp_err_d = 1'b0;
    end else begin
      resp_err_d = resp_err_q;
    end
  end

  // Write request stage: the popped line is presented one cycle later.
  always_comb begin
    req_valid_d = issue_s;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    if (issue_s) begin
      req_addr_d = issue_addr_s;
      req_data_d = fifo_deq_data;
    end else begin
      req_addr_d = req_addr_q;
      req_data_d = req_data_q;
    end
  end

  // Status flags follow the next state so they change with the state itself.
  always_comb begin
    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // Control and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      base_q        <= {ADDR_WIDTH{1'b0}};
      num_q         <= {LEN_WIDTH{1'b0}};
      sent_q        <= {LEN_WIDTH{1'b0}};
      acked_q       <= {LEN_WIDTH{1'b0}};
      outstanding_q <= {OUT_W{1'b0}};
      resp_err_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      num_q         <= num_d;
      sent_q        <= sent_d;
      acked_q       <= acked_d;
      outstanding_q <= outstanding_d;
      resp_err_q    <= resp_err_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Write request output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_valid_q <= 1'b0;
      req_addr_q  <= {ADDR_WIDTH{1'b0}};
      req_data_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
    end
  end

endmodule

// File: tb/tb_loopback_wr_engine.sv
// Self-checking bench for loopback_wr_engine: a FIFO model feeds the DUT, a
// scoreboard holds the expected address/data of every line pushed, and an
// ack model returns responses a fixed number of cycles after each request.
module tb_loopback_wr_engine;

  localparam int DW  = 512;
  localparam int AW  = 42;
  localparam int LW  = 32;
  localparam int MO  = 16;
  localparam int UNL = 1000000;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] num_lines;
  logic [DW-1:0] fifo_deq_data;
  logic          fifo_empty;
  logic          fifo_deq_en;
  logic          wr_almost_full;
  logic          wr_req_valid;
  logic [AW-1:0] wr_req_addr;
  logic [DW-1:0] wr_req_data;
  logic          wr_rsp_valid;
  logic          busy;
  logic          done;
  logic          resp_error;
  logic [LW-1:0] lines_sent;
  logic [LW-1:0] lines_acked;

  loopback_wr_engine #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .num_lines(num_lines), .fifo_deq_data(fifo_deq_data),
    .fifo_empty(fifo_empty), .fifo_deq_en(fifo_deq_en),
    .wr_almost_full(wr_almost_full), .wr_req_valid(wr_req_valid),
    .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .wr_rsp_valid(wr_rsp_valid), .busy(busy), .done(done),
    .resp_error(resp_error), .lines_sent(lines_sent),
    .lines_acked(lines_acked)
  );

  logic [DW-1:0] fifo_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  int            pend_q[$];
  int            req_cyc_q[$];
  int            cyc;
  int            req_count;
  int            pop_count;
  int            ack_credit;
  bit            stray_req;
  bit            fifo_gap;
  logic          deq_seen;
  logic          stall_seen;
  logic [AW-1:0] job_base;
  int            job_idx;
  int            n_checks;
  int            n_errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [DW-1:0] obs,
                          input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Capture what the DUT saw at the active edge.
  always @(posedge clk) begin
    deq_seen   <= fifo_deq_en;
    stall_seen <= fifo_empty || wr_almost_full;
  end

  // FIFO model, scoreboard and ack model, all evaluated on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (deq_seen === 1'b1) begin
      pop_count++;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    if (stall_seen === 1'b1) check_eq("no_pop_stall", DW'(deq_seen), DW'(0));
    if (wr_req_valid === 1'b1) begin
      req_count++;
      req_cyc_q.push_back(cyc);
      pend_q.push_back(cyc + 3);
      if (exp_addr_q.size() == 0) begin
        check_eq("unexpected_req", DW'(1), DW'(0));
      end else begin
        check_eq("req_addr", DW'(wr_req_addr), DW'(exp_addr_q.pop_front()));
        check_eq("req_data", wr_req_data, exp_data_q.pop_front());
      end
    end
    wr_rsp_valid = 1'b0;
    if (stray_req) begin
      wr_rsp_valid = 1'b1;
      stray_req    = 1'b0;
    end else if (ack_credit > 0 && pend_q.size() > 0 && pend_q[0] <= cyc) begin
      void'(pend_q.pop_front());
      wr_rsp_valid = 1'b1;
      if (ack_credit < UNL) ack_credit--;
    end
    fifo_empty    = fifo_gap || (fifo_q.size() == 0);
    fifo_deq_data = (fifo_q.size() == 0) ? {DW{1'b0}} : fifo_q[0];
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_lines(input int n);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
      fifo_q.push_back(d);
      exp_data_q.push_back(d);
      exp_addr_q.push_back(job_base + AW'(job_idx));
      job_idx++;
    end
  endtask

  task automatic start_job(input logic [AW-1:0] b, input int num,
                           input int prefill);
    job_base = b;
    job_idx  = 0;
    req_cyc_q.delete();
    push_lines(prefill);
    start     = 1'b1;
    base_addr = b;
    num_lines = LW'(num);
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input int num);
    int i;
    i = 0;
    while (done !== 1'b1 && i < max_cyc) begin
      tick(1);
      i++;
    end
    check_eq("done_reached", DW'(done), DW'(1));
    check_eq("acked_at_done", DW'(lines_acked), DW'(num));
    check_eq("sent_at_done", DW'(lines_sent), DW'(num));
    check_eq("busy_at_done", DW'(busy), DW'(0));
    check_eq("sb_empty", DW'(exp_addr_q.size()), DW'(0));
  endtask

  initial begin
    logic [AW-1:0] wrap_base;
    int r0;
    int p0;
    n_checks = 0; n_errors = 0; cyc = 0; req_count = 0; pop_count = 0;
    ack_credit = UNL; stray_req = 1'b0; fifo_gap = 1'b0;
    reset_n = 1'b0; start = 1'b0; base_addr = '0; num_lines = '0;
    wr_almost_full = 1'b0; wr_rsp_valid = 1'b0;
    fifo_empty = 1'b1; fifo_deq_data = '0;
    job_base = '0; job_idx = 0;
    tick(3);
    reset_n = 1'b1;
    tick(2);

    // Reset state
    check_eq("rst_busy", DW'(busy), DW'(0));
    check_eq("rst_done", DW'(done), DW'(0));
    check_eq("rst_valid", DW'(wr_req_valid), DW'(0));
    check_eq("rst_addr", DW'(wr_req_addr), DW'(0));
    check_eq("rst_sent", DW'(lines_sent), DW'(0));
    check_eq("rst_err", DW'(resp_error), DW'(0));

    // Stray ack while idle
    stray_req = 1'b1;
    tick(2);
    check_eq("stray_err", DW'(resp_error), DW'(1));
    check_eq("stray_acked", DW'(lines_acked), DW'(0));
    check_eq("stray_busy", DW'(busy), DW'(0));

    // Basic job, back-to-back requests, start clears resp_error
    start_job(AW'(42'h100), 4, 4);
    wait_done(100, 4);
    check_eq("t1_err_clr", DW'(resp_error), DW'(0));
    check_eq("t1_nreq", DW'(req_cyc_q.size()), DW'(4));
    if (req_cyc_q.size() == 4)
      check_eq("t1_b2b", DW'(req_cyc_q[3] - req_cyc_q[0]), DW'(3));

    // Zero-length job
    r0 = req_count; p0 = pop_count;
    fifo_q.push_back({DW{1'b1}});
    start_job(AW'(42'h200), 0, 0);
    check_eq("t2_done", DW'(done), DW'(1));
    check_eq("t2_busy", DW'(busy), DW'(0));
    tick(4);
    check_eq("t2_nopop", DW'(pop_count - p0), DW'(0));
    check_eq("t2_noreq", DW'(req_count - r0), DW'(0));
    fifo_q.delete();
    tick(1);

    // Outstanding limit
    ack_credit = 0;
    r0 = req_count;
    start_job(AW'(42'h400), 32, 32);
    tick(40);
    check_eq("t3_limit_reqs", DW'(req_count - r0), DW'(MO));
    check_eq("t3_limit_sent", DW'(lines_sent), DW'(MO));
    check_eq("t3_busy", DW'(busy), DW'(1));
    ack_credit = 1;
    tick(10);
    check_eq("t3_one_more", DW'(req_count - r0), DW'(MO + 1));
    check_eq("t3_acked1", DW'(lines_acked), DW'(1));
    ack_credit = UNL;
    wait_done(400, 32);

    // Backpressure and FIFO gaps
    start_job(AW'(42'h1000), 12, 6);
    tick(3);
    wr_almost_full = 1'b1;
    tick(5);
    wr_almost_full = 1'b0;
    push_lines(6);
    for (int i = 0; i < 10; i++) begin
      fifo_gap = (i % 3 == 0);
      tick(1);
    end
    fifo_gap = 1'b0;
    wait_done(200, 12);

    // Address wrap
    wrap_base = '1;
    wrap_base = wrap_base - AW'(1);
    start_job(wrap_base, 4, 4);
    wait_done(100, 4);
    check_eq("t5_last_addr", DW'(wr_req_addr), DW'(1));

    // Reset in the middle of a job, then restart
    ack_credit = 0;
    start_job(AW'(42'h40), 8, 8);
    tick(4);
    reset_n = 1'b0;
    #1;
    check_eq("arst_busy", DW'(busy), DW'(0));
    check_eq("arst_valid", DW'(wr_req_valid), DW'(0));
    check_eq("arst_addr", DW'(wr_req_addr), DW'(0));
    check_eq("arst_data", wr_req_data, DW'(0));
    check_eq("arst_sent", DW'(lines_sent), DW'(0));
    check_eq("arst_deq", DW'(fifo_deq_en), DW'(0));
    fifo_q.delete(); exp_addr_q.delete(); exp_data_q.delete(); pend_q.delete();
    wr_rsp_valid = 1'b0;
    ack_credit = UNL;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    check_eq("arst_acked", DW'(lines_acked), DW'(0));
    start_job(AW'(42'h80), 3, 3);
    wait_done(100, 3);
    check_eq("t6_err", DW'(resp_error), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
